ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist_pkg.sv | 19 +
 rtl/ram_bist_if.sv | 16 +
 rtl/ram_bist_addr_ctr.sv | 45 ++++
 rtl/ram_bist.sv | 139 +++++++++++++
 tb/tb_ram_bist.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared state encoding and test-pattern function for the RAM BIST.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Pattern for address k is 2*k; callers truncate to the RAM word width,
    // which gives the required mod 2^WORD_SIZE wrap.
    function automatic logic [31:0] pattern(input logic [31:0] k);
        return k << 1;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if: RAM-side bus between the BIST engine (master) and the RAM (slave).
// Latency: addr/data_in/wr/cs are registered by the master; data_out is combinational.
// Backpressure: none, the RAM accepts one access per cycle.
interface ram_bist_if #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8
);
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data_in;
    logic [WORD_SIZE-1:0] data_out;
    logic                 wr;
    logic                 cs;

    modport master (output addr, output data_in, output wr, output cs, input data_out);
    modport slave  (input addr, input data_in, input wr, input cs, output data_out);
endinterface

// File: rtl/ram_bist_addr_ctr.sv
// ram_bist_addr_ctr: word index k with clear, increment and terminal-count flag.
// Latency: count updates one cycle after clr_i/inc_i; tc_o is combinational on the count.
// Backpressure: none, count holds when neither clr_i nor inc_i is asserted.
module ram_bist_addr_ctr #(
    parameter int ADDR_SIZE   = 10,
    parameter int MEMORY_SIZE = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [ADDR_SIZE:0] cnt_o,
    output logic [ADDR_SIZE:0] cnt_nxt_o,
    output logic             tc_o
);
    // One spare bit so MEMORY_SIZE == 2**ADDR_SIZE never wraps the count.
    localparam int CW = ADDR_SIZE + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;
    assign tc_o      = (cnt_q == CW'(MEMORY_SIZE - 1));

endmodule

// File: rtl/ram_bist.sv
// ram_bist: write 2*k to every word, read it back, report pass and first failing address.
// Latency: 2*MEMORY_SIZE cycles from the first WRITE cycle to the first DONE cycle.
// Backpressure: none; start is accepted only in IDLE/DONE. Optional RAM_BIST_ERRCNT_EN adds err_cnt.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int ADDR_SIZE   = 10,
    parameter int WORD_SIZE   = 8,
    parameter int MEMORY_SIZE = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    ram_bist_if.master           ram,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_SIZE-1:0] fail_addr
`ifdef RAM_BIST_ERRCNT_EN
    ,
    output logic [ADDR_SIZE:0]   err_cnt
`endif
);

    state_e                 state_q, state_d;
    logic                   ctr_clr, ctr_inc, ctr_tc;
    logic [ADDR_SIZE:0]     ctr_q, ctr_nxt;
    logic                   launch;
    logic                   mismatch;

    logic [WORD_SIZE-1:0]   data_in_q;
    logic                   wr_q, cs_q;
    logic                   err_q;
    logic [ADDR_SIZE-1:0]   fail_addr_q;

    ram_bist_addr_ctr #(
        .ADDR_SIZE   (ADDR_SIZE),
        .MEMORY_SIZE (MEMORY_SIZE)
    ) u_addr_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ctr_clr),
        .inc_i     (ctr_inc),
        .cnt_o     (ctr_q),
        .cnt_nxt_o (ctr_nxt),
        .tc_o      (ctr_tc)
    );

    // Next state and counter control; start is only looked at in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        ctr_clr = 1'b0;
        ctr_inc = 1'b0;
        launch  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WRITE;
                    ctr_clr = 1'b1;
                    launch  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (ctr_tc) begin
                    state_d = ST_READ;
                    ctr_clr = 1'b1;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            ST_READ: begin
                if (ctr_tc) begin
                    state_d = ST_DONE;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-back compare against the pattern for the word addressed this cycle.
    assign mismatch = (state_q == ST_READ) &&
                      (ram.data_out != WORD_SIZE'(pattern(32'(ctr_q))));

    // State, registered RAM controls and the sticky first-failure record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_in_q   <= '0;
            wr_q        <= 1'b0;
            cs_q        <= 1'b0;
            err_q       <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= (state_d == ST_WRITE);
            cs_q      <= (state_d == ST_WRITE) || (state_d == ST_READ);
            data_in_q <= (state_d == ST_WRITE) ? WORD_SIZE'(pattern(32'(ctr_nxt))) : '0;
            if (launch) begin
                err_q       <= 1'b0;
                fail_addr_q <= '0;
            end else if (mismatch && !err_q) begin
                err_q       <= 1'b1;
                fail_addr_q <= ctr_q[ADDR_SIZE-1:0];
            end
        end
    end

`ifdef RAM_BIST_ERRCNT_EN
    logic [ADDR_SIZE:0] err_cnt_q;

    // Saturating count of every read mismatch in the current run.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (launch) begin
            err_cnt_q <= '0;
        end else if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + (ADDR_SIZE + 1)'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    // The address counter is itself a register loaded with the next k, so it
    // drives the RAM address directly.
    assign ram.addr    = ctr_q[ADDR_SIZE-1:0];
    assign ram.data_in = data_in_q;
    assign ram.wr      = wr_q;
    assign ram.cs      = cs_q;

    assign busy      = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && !err_q;
    assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: scoreboard bench for ram_bist with a 1024x8 behavioural RAM and fault injection.
// Latency: expects the first DONE cycle 2048 cycles after the first WRITE cycle.
// Backpressure: n/a; every wait is bounded and an expired bound counts as an error.
module tb_ram_bist;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MS = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
`ifdef RAM_BIST_ERRCNT_EN
    logic [AW:0]   err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_bist_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) ram_if ();

    ram_bist #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MEMORY_SIZE(MS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ram       (ram_if),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr)
`ifdef RAM_BIST_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    // ---------------- RAM model with fault injection ----------------
    logic [DW-1:0] mem [MS];
    logic          mem_wipe     = 1'b0;
    int            fault_mode   = 0;    // 0 none, 1 bit0 stuck-at-0, 2 bit0 stuck-at-1
    logic          corrupt_en   = 1'b0; // word corrupt_addr reads back as 0
    logic [AW-1:0] corrupt_addr = '0;
    logic [DW-1:0] rd;

    always @(posedge clk) begin
        if (mem_wipe) begin
            for (int i = 0; i < MS; i++) mem[i] <= 8'hFF;
        end else if (ram_if.cs && ram_if.wr) begin
            mem[ram_if.addr] <= ram_if.data_in;
        end
    end

    always_comb begin
        rd = mem[ram_if.addr];
        if (corrupt_en && (ram_if.addr == corrupt_addr)) rd = '0;
        if (fault_mode == 1) rd[0] = 1'b0;
        else if (fault_mode == 2) rd[0] = 1'b1;
    end
    assign ram_if.data_out = rd;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        bit            pass;
        logic [AW-1:0] fa;
        int            errs;
    } res_t;

    wr_t  wr_q [$];
    res_t res_q [$];

    task automatic push_writes(input int n);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e.a = AW'(k);
            e.d = DW'((2 * k) % 256);
            wr_q.push_back(e);
        end
    endtask

    task automatic push_result(input bit p, input int fa, input int errs);
        res_t r;
        r.pass = p;
        r.fa   = AW'(fa);
        r.errs = errs;
        res_q.push_back(r);
    endtask

    // Every RAM write must match the next expected (addr, data).
    always @(negedge clk) begin
        wr_t e;
        if (ram_if.wr === 1'b1) begin
            checks++;
            if (ram_if.cs !== 1'b1 || busy !== 1'b1 || wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%0d cs=%b busy=%b, required no write",
                         ram_if.addr, ram_if.data_in, ram_if.cs, busy);
            end else begin
                e = wr_q.pop_front();
                if ({ram_if.addr, ram_if.data_in} !== e) begin
                    errors++;
                    $display("FAIL write_stream: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             ram_if.addr, ram_if.data_in, e.a, e.d);
                end
            end
        end
    end

    // Measure run length and compare the outcome when done first rises.
    int   run_cyc   = 0;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        res_t r;
        if (busy === 1'b1 && busy_prev !== 1'b1) run_cyc = 0;
        else run_cyc++;
        if (done === 1'b1 && done_prev !== 1'b1) begin
            checks++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done rose with no run expected");
            end else begin
                r = res_q.pop_front();
                if (run_cyc !== 2 * MS) begin
                    errors++;
                    $display("FAIL run_length: got %0d cycles, required %0d", run_cyc, 2 * MS);
                end
                checks++;
                if (pass !== r.pass) begin
                    errors++;
                    $display("FAIL pass: got %b, required %b", pass, r.pass);
                end
                checks++;
                if (fail_addr !== r.fa) begin
                    errors++;
                    $display("FAIL fail_addr: got %0d, required %0d", fail_addr, r.fa);
                end
`ifdef RAM_BIST_ERRCNT_EN
                checks++;
                if (err_cnt !== (AW + 1)'(r.errs)) begin
                    errors++;
                    $display("FAIL err_cnt: got %0d, required %0d", err_cnt, r.errs);
                end
`endif
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    // Entered at the negedge of the first WRITE cycle; optionally pulses start
    // during cycle indices pa/pb and waits (bounded) for done.
    task automatic wait_done(input int pa, input int pb, output bit ok);
        int cyc;
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 3 * MS; n++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc++;
            start = (cyc == pa) || (cyc == pb);
            @(negedge clk);
        end
        start = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mem_wipe = 1'b1;
        repeat (3) @(negedge clk);
        mem_wipe = 1'b0;
        checks++;
        if ({ram_if.addr, ram_if.data_in, ram_if.wr, ram_if.cs, busy, done, pass, fail_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: addr=%0d data_in=%0d wr=%b cs=%b busy=%b done=%b pass=%b fail_addr=%0d, required all 0",
                     ram_if.addr, ram_if.data_in, ram_if.wr, ram_if.cs, busy, done, pass, fail_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        push_writes(MS);
        push_result(1'b1, 0, 0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || ram_if.wr !== 1'b1 || ram_if.addr !== '0) begin
            errors++;
            $display("FAIL first_write_cycle: busy=%b wr=%b addr=%0d, required 1 1 0", busy, ram_if.wr, ram_if.addr);
        end
        wait_done(-1, -1, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: done=%b, required 1", done); end
        checks++;
        if (mem[5] !== 8'd10 || mem[200] !== 8'd144) begin
            errors++;
            $display("FAIL mem_contents: mem[5]=%0d mem[200]=%0d, required 10 144", mem[5], mem[200]);
        end
        checks++;
        if (ram_if.wr !== 1'b0 || ram_if.cs !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_idle_bus: wr=%b cs=%b busy=%b, required 0 0 0", ram_if.wr, ram_if.cs, busy);
        end
        checks++;
        if (wr_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL basic_queues: writes left=%0d results left=%0d, required 0 0", wr_q.size(), res_q.size());
        end
    endtask

    task automatic test_run(input string name, input int pa, input int pb,
                            input bit p, input int fa, input int errs);
        bit ok;
        push_writes(MS);
        push_result(p, fa, errs);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done(pa, pb, ok);
        checks++;
        if (ok !== 1'b1 || wr_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL %s_complete: done=%b writes left=%0d results left=%0d, required 1 0 0",
                     name, ok, wr_q.size(), res_q.size());
        end
    endtask

    task automatic test_restart_from_done();
        bit ok;
        corrupt_en = 1'b0;
        push_writes(MS);
        push_result(1'b1, 0, 0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || fail_addr !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: done=%b pass=%b fail_addr=%0d busy=%b, required 0 0 0 1",
                     done, pass, fail_addr, busy);
        end
        wait_done(-1, -1, ok);
        checks++;
        if (ok !== 1'b1 || res_q.size() != 0) begin
            errors++;
            $display("FAIL restart_complete: done=%b results left=%0d, required 1 0", ok, res_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        int bad;
        mem_wipe = 1'b1; @(negedge clk); mem_wipe = 1'b0;
        push_writes(600);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (599) @(negedge clk);
        // Reset is sampled at the edge that would begin the k=600 cycle.
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_if.wr !== 1'b0 || ram_if.cs !== 1'b0 || busy !== 1'b0 || ram_if.addr !== '0) begin
            errors++;
            $display("FAIL reset_abort: wr=%b cs=%b busy=%b addr=%0d, required 0 0 0 0",
                     ram_if.wr, ram_if.cs, busy, ram_if.addr);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        bad = 0;
        for (int i = 600; i < MS; i++) if (mem[i] !== 8'hFF) bad++;
        checks++;
        if (bad != 0 || mem[599] !== 8'd174 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL reset_partial_write: written_above_599=%0d mem[599]=%0d writes left=%0d, required 0 174 0",
                     bad, mem[599], wr_q.size());
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        push_writes(MS);
        push_result(1'b1, 0, 0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done(-1, -1, ok);
        checks++;
        if (ok !== 1'b1 || res_q.size() != 0) begin
            errors++;
            $display("FAIL reset_rerun: done=%b results left=%0d, required 1 0", ok, res_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic();
        fault_mode = 1;
        test_run("stuck0", -1, -1, 1'b1, 0, 0);
        fault_mode = 2;
        test_run("stuck1", -1, -1, 1'b0, 0, MS);
        fault_mode = 0;
        test_run("start_while_busy", 10, MS + 500, 1'b1, 0, 0);
        test_reset_mid_write();
        corrupt_addr = AW'(300);
        corrupt_en   = 1'b1;
        test_run("corrupt300", -1, -1, 1'b0, 300, 1);
        test_restart_from_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
